// File: rtl/rx_byte_fifo_if.sv
// Byte-stream handshake between the UART receiver, the FIFO and its consumers.
// The master modport is the producer/consumer side; the slave modport is the FIFO.
interface rx_byte_fifo_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic                  wr_valid;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_en;
   logic                  clear_ovf;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  empty;
   logic                  full;
   logic [ADDR_WIDTH:0]   count;
   logic                  overflow;

   modport master (
      output wr_valid, wr_data, rd_en, clear_ovf,
      input  rd_data, rd_valid, empty, full, count, overflow
   );

   modport slave (
      input  wr_valid, wr_data, rd_en, clear_ovf,
      output rd_data, rd_valid, empty, full, count, overflow
   );
endinterface

// File: rtl/rx_byte_fifo.sv
// Receive byte FIFO: absorbs one-cycle receiver strobes and hands bytes out on
// request with a registered one-cycle read latency and a sticky overflow flag.
module rx_byte_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   rx_byte_fifo_if.slave    bus
);
   localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
   logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  ovf_q, ovf_d;
   logic                  pop, push, drop;

   // A pop frees a slot in the same cycle, so a write at full still fits.
   always_comb begin
      pop        = bus.rd_en && (count_q != '0);
      push       = bus.wr_valid && ((count_q != FULL_CNT) || pop);
      drop       = bus.wr_valid && !push;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      ovf_d      = ovf_q;

      if (push) wptr_d = wptr_q + ADDR_WIDTH'(1);
      if (pop) begin
         rptr_d     = rptr_q + ADDR_WIDTH'(1);
         rd_data_d  = mem_q[rptr_q];
         rd_valid_d = 1'b1;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
         2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
         default: count_d = count_q;
      endcase

      // Setting on a dropped byte takes priority over a clear request.
      if (drop)               ovf_d = 1'b1;
      else if (bus.clear_ovf) ovf_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         ovf_q      <= ovf_d;
      end
   end

   // Storage is intentionally left out of reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= bus.wr_data;
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.count    = count_q;
   assign bus.empty    = (count_q == '0);
   assign bus.full     = (count_q == FULL_CNT);
   assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_rx_byte_fifo.sv
// Directed bench for rx_byte_fifo: ordering, fill/overflow, simultaneous
// push/pop at full and empty, and asynchronous reset mid-stream.
module tb_rx_byte_fifo;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   rx_byte_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

   rx_byte_fifo #(.DATA_WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset         = 1'b0;
      bus.wr_valid  = 1'b0;
      bus.wr_data   = 8'h00;
      bus.rd_en     = 1'b0;
      bus.clear_ovf = 1'b0;

      // Reset then idle
      repeat (3) tick();
      reset = 1'b1;
      tick();
      chk("rst_empty",    32'(bus.empty),    32'd1);
      chk("rst_full",     32'(bus.full),     32'd0);
      chk("rst_count",    32'(bus.count),    32'd0);
      chk("rst_overflow", 32'(bus.overflow), 32'd0);
      chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
      chk("rst_rd_data",  32'(bus.rd_data),  32'h00);

      // Ordered transfer
      bus.wr_valid = 1'b1;
      bus.wr_data = 8'h41; tick();
      bus.wr_data = 8'h42; tick();
      bus.wr_data = 8'h43; tick();
      bus.wr_valid = 1'b0;
      chk("ord_count3", 32'(bus.count), 32'd3);
      bus.rd_en = 1'b1;
      tick();
      chk("ord_v0", 32'(bus.rd_valid), 32'd1);
      chk("ord_d0", 32'(bus.rd_data), 32'h41);
      chk("ord_c2", 32'(bus.count), 32'd2);
      tick();
      chk("ord_v1", 32'(bus.rd_valid), 32'd1);
      chk("ord_d1", 32'(bus.rd_data), 32'h42);
      chk("ord_c1", 32'(bus.count), 32'd1);
      tick();
      chk("ord_v2", 32'(bus.rd_valid), 32'd1);
      chk("ord_d2", 32'(bus.rd_data), 32'h43);
      chk("ord_c0", 32'(bus.count), 32'd0);
      bus.rd_en = 1'b0;
      tick();
      chk("ord_v_end", 32'(bus.rd_valid), 32'd0);
      chk("ord_empty", 32'(bus.empty), 32'd1);
      chk("ord_hold",  32'(bus.rd_data), 32'h43);

      // Fill and overflow
      for (int i = 0; i < 17; i++) begin
         bus.wr_valid = 1'b1;
         bus.wr_data = 8'(i);
         tick();
         if (i == 15) begin
            chk("fill_full16",  32'(bus.full), 32'd1);
            chk("fill_count16", 32'(bus.count), 32'd16);
            chk("fill_ovf16",   32'(bus.overflow), 32'd0);
         end
      end
      bus.wr_valid = 1'b0;
      chk("ovf_set",   32'(bus.overflow), 32'd1);
      chk("ovf_count", 32'(bus.count), 32'd16);
      bus.rd_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("drain_v", 32'(bus.rd_valid), 32'd1);
         chk("drain_d", 32'(bus.rd_data), 32'(i));
      end
      bus.rd_en = 1'b0;
      tick();
      chk("drain_empty", 32'(bus.empty), 32'd1);
      chk("ovf_sticky",  32'(bus.overflow), 32'd1);
      bus.clear_ovf = 1'b1;
      tick();
      bus.clear_ovf = 1'b0;
      chk("ovf_clear", 32'(bus.overflow), 32'd0);

      // Simultaneous push/pop at full, then set-beats-clear
      for (int i = 0; i < 16; i++) begin
         bus.wr_valid = 1'b1;
         bus.wr_data = 8'(i);
         tick();
      end
      chk("sf_full", 32'(bus.full), 32'd1);
      bus.wr_data = 8'hAA;
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      chk("sf_rd_data", 32'(bus.rd_data), 32'h00);
      chk("sf_rd_valid", 32'(bus.rd_valid), 32'd1);
      chk("sf_count", 32'(bus.count), 32'd16);
      chk("sf_ovf", 32'(bus.overflow), 32'd0);
      bus.wr_data = 8'hBB;
      bus.clear_ovf = 1'b1;
      tick();
      bus.wr_valid = 1'b0;
      chk("set_wins", 32'(bus.overflow), 32'd1);
      chk("drop_count", 32'(bus.count), 32'd16);
      tick();
      bus.clear_ovf = 1'b0;
      chk("clear_again", 32'(bus.overflow), 32'd0);
      bus.rd_en = 1'b1;
      for (int i = 1; i < 16; i++) begin
         tick();
         chk("wrap_d", 32'(bus.rd_data), 32'(i));
      end
      tick();
      bus.rd_en = 1'b0;
      chk("wrap_last", 32'(bus.rd_data), 32'hAA);
      chk("wrap_empty", 32'(bus.empty), 32'd1);

      // Read on empty, simultaneous at empty
      bus.rd_en = 1'b1;
      tick();
      chk("re_valid", 32'(bus.rd_valid), 32'd0);
      chk("re_hold", 32'(bus.rd_data), 32'hAA);
      chk("re_count", 32'(bus.count), 32'd0);
      bus.wr_valid = 1'b1;
      bus.wr_data = 8'h55;
      tick();
      bus.wr_valid = 1'b0;
      chk("se_count", 32'(bus.count), 32'd1);
      chk("se_valid", 32'(bus.rd_valid), 32'd0);
      chk("se_hold", 32'(bus.rd_data), 32'hAA);
      tick();
      bus.rd_en = 1'b0;
      chk("se_rd_data", 32'(bus.rd_data), 32'h55);
      chk("se_rd_valid", 32'(bus.rd_valid), 32'd1);
      chk("se_count0", 32'(bus.count), 32'd0);

      // Asynchronous reset mid-stream
      bus.wr_valid = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         bus.wr_data = 8'(i);
         tick();
      end
      bus.wr_valid = 1'b0;
      bus.rd_en = 1'b1;
      tick();
      chk("ar_count5", 32'(bus.count), 32'd5);
      chk("ar_pre_valid", 32'(bus.rd_valid), 32'd1);
      chk("ar_pre_data", 32'(bus.rd_data), 32'h01);
      #2;
      bus.rd_en = 1'b0;
      reset = 1'b0;
      #1;
      chk("ar_count", 32'(bus.count), 32'd0);
      chk("ar_empty", 32'(bus.empty), 32'd1);
      chk("ar_valid", 32'(bus.rd_valid), 32'd0);
      chk("ar_data", 32'(bus.rd_data), 32'h00);
      tick();
      #1;
      reset = 1'b1;
      bus.wr_valid = 1'b1;
      bus.wr_data = 8'h77;
      tick();
      bus.wr_valid = 1'b0;
      chk("ar_wcount", 32'(bus.count), 32'd1);
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      chk("ar_rd_data", 32'(bus.rd_data), 32'h77);
      chk("ar_rd_valid", 32'(bus.rd_valid), 32'd1);
      tick();
      chk("ar_pulse", 32'(bus.rd_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/rx_byte_fifo.md
Name: rx_byte_fifo

Overview:
- Buffers bytes produced by the UART receiver stage. The receiver pulses a one-cycle strobe per completed byte.
- Presents buffered bytes to downstream consumers (LED display, echo/transmit path) through a read-request handshake.
- Decouples receiver timing from consumer timing so back-to-back frames are not lost.
- Reports occupancy and a sticky overflow flag.

Parameters:
- DATA_WIDTH, 8, width of each stored byte.
- DEPTH, 16, number of entries; must be a power of two, minimum 2.
- ADDR_WIDTH, 4, log2(DEPTH); pointer width.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- wr_valid  input  1  one-cycle strobe from receiver: wr_data holds a complete byte.
- wr_data  input  DATA_WIDTH  received byte, sampled when wr_valid=1.
- rd_en  input  1  consumer request to pop one entry.
- clear_ovf  input  1  clears the sticky overflow flag.
- rd_data  output  DATA_WIDTH  popped byte, registered; holds its value until the next successful pop.
- rd_valid  output  1  one-cycle pulse: rd_data was updated this cycle.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- count  output  ADDR_WIDTH+1  current number of stored entries, 0..DEPTH.
- overflow  output  1  sticky flag: a write was dropped.

Behaviour:
- Reset (reset=0, asynchronous):
  - Write and read pointers = 0; count = 0.
  - rd_data = 0, rd_valid = 0, overflow = 0.
  - empty = 1, full = 0.
  - Storage array contents are not reset; they are don't-care.
- Pointers are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0. count is maintained as a separate register.
- Write accepted when wr_valid=1 and (not full, or a pop is accepted in the same cycle):
  - mem[wptr] <= wr_data; wptr increments.
- Pop accepted when rd_en=1 and not empty (registered values at the start of the cycle):
  - rd_data <= mem[rptr]; rd_valid <= 1 next cycle; rptr increments.
  - Latency: rd_en at edge N gives rd_data/rd_valid visible after edge N+1 (one cycle).
- rd_en while empty: ignored. rd_data is held, rd_valid stays 0, and no error is flagged.
- Simultaneous write and pop:
  - Both proceed and count is unchanged.
  - When full: the pop frees the slot and the write is accepted, with no overflow.
  - When empty: the pop is ignored and the write is accepted. A new byte is never bypassed to the output in the same cycle, so it is readable no earlier than the following cycle.
- Write while full with no accepted pop:
  - The byte is dropped; pointers and count are unchanged.
  - overflow <= 1 and holds until clear_ovf=1 or reset.
- clear_ovf and a new dropped write in the same cycle: set wins, so overflow stays 1.
- count updates: +1 on write only, -1 on pop only, unchanged on both or neither. full and empty are derived combinationally from registered count.
- rd_valid is a single-cycle pulse. Continuous rd_en drains one entry per cycle, with back-to-back rd_valid pulses.
- Reset asserted mid-operation: all state clears immediately and asynchronously, and any buffered bytes are discarded. Reset deassertion is synchronised externally; this block needs no behaviour beyond first-edge-after-release operation.
- No internal state machine beyond pointer/count control; no combinational path from wr_* to rd_*.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release → empty=1, full=0, count=0, overflow=0, rd_valid=0, rd_data=0x00.
- Ordered transfer: write 0x41, 0x42, 0x43 on separate cycles, then rd_en for 3 consecutive cycles → rd_valid pulses on 3 consecutive cycles carrying 0x41, 0x42, 0x43; count steps 3→0; empty=1 after.
- Fill and overflow: write 17 bytes 0x00..0x10 with no reads → full=1, count=16 after the 16th; the 17th (0x10) sets overflow=1; draining 16 returns 0x00..0x0F; clear_ovf pulse → overflow=0.
- Simultaneous at full: with the FIFO full (0x00..0x0F), assert wr_valid=1 with 0xAA and rd_en=1 in one cycle → rd_data=0x00, count stays 16, overflow stays 0; final drained byte is 0xAA after 0x0F, confirming wrap-around.
- Read on empty and simultaneous at empty: rd_en with empty=1 → no rd_valid, rd_data unchanged; wr_valid 0x55 with rd_en in the same cycle → count=1, no rd_valid; next-cycle rd_en → rd_data=0x55.
- Async reset mid-stream: with count=5, drive reset=0 between clock edges → count=0, empty=1, rd_valid=0 immediately without waiting for a clock edge; a subsequent write of 0x77 then read returns 0x77.
